// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_ALU  = 2'd1,
        WB_SRC_LSU  = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_starve_ctr.sv
// Saturating count of consecutive contentions the ALU has lost to the LSU.
// alu_priority rises once the ALU has lost STARVE_MAX times in a row.
module wb_starve_ctr #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic alu_valid,
    input  logic alu_gnt,
    input  logic lsu_gnt,
    output logic alu_priority
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;

    // A lost contention is an LSU grant while the ALU was also asking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (flush || !alu_valid || alu_gnt) begin
            starve_cnt <= '0;
        end else if (lsu_gnt && starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign alu_priority = (starve_cnt == CNT_MAX);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single write port arbiter for the 32x32 register file: LSU has fixed
// priority, the starvation counter guarantees the ALU eventually wins.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  alu_valid_i,
    input  logic [REG_ADDR_W-1:0] alu_rd_addr_i,
    input  logic [XLEN-1:0]       alu_rd_data_i,
    output logic                  alu_ready_o,
    input  logic                  lsu_valid_i,
    input  logic [REG_ADDR_W-1:0] lsu_rd_addr_i,
    input  logic [XLEN-1:0]       lsu_rd_data_i,
    output logic                  lsu_ready_o,
    output logic                  rd_wren_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic [XLEN-1:0]       rd_data_o,
    output wb_src_e               wb_src_o
);

    logic alu_priority;
    logic alu_gnt;
    logic lsu_gnt;

    logic                  wren_p1;
    logic [REG_ADDR_W-1:0] addr_p1;
    logic [XLEN-1:0]       data_p1;
    wb_src_e               src_p1;

    wb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk          (clk_i),
        .rst_n        (rst_ni),
        .flush        (flush_i),
        .alu_valid    (alu_valid_i),
        .alu_gnt      (alu_gnt),
        .lsu_gnt      (lsu_gnt),
        .alu_priority (alu_priority)
    );

    // Grant selection: nothing during reset or flush, otherwise LSU first
    // unless the ALU has been starved long enough.
    always_comb begin
        alu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        if (rst_ni && !flush_i) begin
            if (alu_valid_i && (!lsu_valid_i || alu_priority)) begin
                alu_gnt = 1'b1;
            end else if (lsu_valid_i) begin
                lsu_gnt = 1'b1;
            end
        end
    end

    assign alu_ready_o = alu_gnt;
    assign lsu_ready_o = lsu_gnt;

    // ---- stage p1: registered write toward the register file ----
    // Writes to x0 still load addr/data but never raise the write enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wren_p1 <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
            src_p1  <= WB_SRC_NONE;
        end else if (alu_gnt) begin
            wren_p1 <= (alu_rd_addr_i != '0);
            addr_p1 <= alu_rd_addr_i;
            data_p1 <= alu_rd_data_i;
            src_p1  <= WB_SRC_ALU;
        end else if (lsu_gnt) begin
            wren_p1 <= (lsu_rd_addr_i != '0);
            addr_p1 <= lsu_rd_addr_i;
            data_p1 <= lsu_rd_data_i;
            src_p1  <= WB_SRC_LSU;
        end else begin
            wren_p1 <= 1'b0;
            src_p1  <= WB_SRC_NONE;
        end
    end

    assign rd_wren_o = wren_p1;
    assign rd_addr_o = addr_p1;
    assign rd_data_o = data_p1;
    assign wb_src_o  = src_p1;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter with a transaction
// level reference model of the grant rules and the writeback register.
module tb_regfile_wb_arbiter;
    import wb_pkg::*;

    localparam int SM = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        alu_valid_i = 1'b0;
    logic [4:0]  alu_rd_addr_i = '0;
    logic [31:0] alu_rd_data_i = '0;
    logic        alu_ready_o;
    logic        lsu_valid_i = 1'b0;
    logic [4:0]  lsu_rd_addr_i = '0;
    logic [31:0] lsu_rd_data_i = '0;
    logic        lsu_ready_o;
    logic        rd_wren_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    wb_src_e     wb_src_o;

    regfile_wb_arbiter #(.STARVE_MAX(SM)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .alu_valid_i   (alu_valid_i),
        .alu_rd_addr_i (alu_rd_addr_i),
        .alu_rd_data_i (alu_rd_data_i),
        .alu_ready_o   (alu_ready_o),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_rd_addr_i (lsu_rd_addr_i),
        .lsu_rd_data_i (lsu_rd_data_i),
        .lsu_ready_o   (lsu_ready_o),
        .rd_wren_o     (rd_wren_o),
        .rd_addr_o     (rd_addr_o),
        .rd_data_o     (rd_data_o),
        .wb_src_o      (wb_src_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_losses = 0;
    int          m_wren = 0;
    int          m_addr = 0;
    int          m_data = 0;
    int          m_src = 0;   // 0 none, 1 alu, 2 lsu

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_rd(input string tag);
        check_val({tag, "_wren"}, 32'(rd_wren_o), 32'(m_wren));
        check_val({tag, "_addr"}, 32'(rd_addr_o), 32'(m_addr));
        check_val({tag, "_data"}, rd_data_o, 32'(m_data));
        check_val({tag, "_src"}, 32'(wb_src_o), 32'(m_src));
    endtask

    // One cycle: apply inputs just after an edge, check ready mid-cycle,
    // then check the registered write after the next edge.
    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic fl, output logic ga, output logic gl);
        alu_valid_i = av; alu_rd_addr_i = aa; alu_rd_data_i = ad;
        lsu_valid_i = lv; lsu_rd_addr_i = la; lsu_rd_data_i = ld;
        flush_i = fl;
        #3;
        ga = 1'b0; gl = 1'b0;
        if (!fl) begin
            if (av && lv) begin
                if (m_losses >= SM) ga = 1'b1; else gl = 1'b1;
            end else begin
                ga = av; gl = lv;
            end
        end
        check_val("alu_ready", 32'(alu_ready_o), 32'(ga));
        check_val("lsu_ready", 32'(lsu_ready_o), 32'(gl));
        if (ga) begin
            m_wren = (aa != 0); m_addr = aa; m_data = ad; m_src = 1;
        end else if (gl) begin
            m_wren = (la != 0); m_addr = la; m_data = ld; m_src = 2;
        end else begin
            m_wren = 0; m_src = 0;
        end
        if (fl || !av || ga) m_losses = 0;
        else if (gl) m_losses++;
        @(posedge clk_i); #1;
        check_rd("rd");
    endtask

    logic ga, gl;
    logic        p_av, p_lv;
    logic [4:0]  p_aa, p_la;
    logic [31:0] p_ad, p_ld;
    int          lsu_run;

    initial begin
        // reset with valids high: ready must stay low
        alu_valid_i = 1'b1; lsu_valid_i = 1'b1;
        #1;
        check_val("rst_alu_ready", 32'(alu_ready_o), 32'd0);
        check_val("rst_lsu_ready", 32'(lsu_ready_o), 32'd0);
        check_rd("rst");
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1'b1;
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
        @(posedge clk_i); #1;

        // idle
        step(0, 0, 0, 0, 0, 0, 0, ga, gl);
        check_val("idle_src", 32'(wb_src_o), 32'(WB_SRC_NONE));

        // single ALU write x5 = 0xAA
        step(1, 5'd5, 32'hAA, 0, 0, 0, 0, ga, gl);
        check_val("alu_single_wren", 32'(rd_wren_o), 32'd1);
        check_val("alu_single_addr", 32'(rd_addr_o), 32'd5);
        check_val("alu_single_data", rd_data_o, 32'hAA);
        check_val("alu_single_src", 32'(wb_src_o), 32'(WB_SRC_ALU));

        // contention: ALU x1 held, LSU streaming x2..x5
        begin
            logic [4:0] la;
            logic       exp_l [5] = '{1, 1, 1, 0, 1};
            la = 5'd2;
            for (int c = 0; c < 5; c++) begin
                step(1, 5'd1, 32'h1111, 1, la, 32'h2000 + 32'(la), 0, ga, gl);
                check_val("cont_lsu_gnt", 32'(lsu_ready_o === 1'bx ? 1'b0 : gl), 32'(exp_l[c]));
                if (gl) la = la + 5'd1;
            end
        end

        // x0 write from LSU
        step(0, 0, 0, 1, 5'd0, 32'hDEAD_BEEF, 0, ga, gl);
        check_val("x0_wren", 32'(rd_wren_o), 32'd0);
        check_val("x0_src", 32'(wb_src_o), 32'(WB_SRC_LSU));
        check_val("x0_data", rd_data_o, 32'hDEAD_BEEF);

        // build up losses, flush, then the ALU must lose SM more times
        step(1, 5'd7, 32'h77, 1, 5'd8, 32'h88, 0, ga, gl);
        step(1, 5'd7, 32'h77, 1, 5'd9, 32'h99, 0, ga, gl);
        step(1, 5'd7, 32'h77, 1, 5'd10, 32'hA0, 1, ga, gl);
        check_val("flush_wren", 32'(rd_wren_o), 32'd0);
        lsu_run = 0;
        for (int c = 0; c < SM + 1; c++) begin
            step(1, 5'd7, 32'h77, 1, 5'(11 + lsu_run), 32'hB0, 0, ga, gl);
            if (gl) lsu_run++;
        end
        check_val("flush_clr_lsu_run", 32'(lsu_run), 32'(SM));

        // reset mid-stream while a write is pending on rd_wren_o
        step(0, 0, 0, 1, 5'd12, 32'hC0FFEE, 0, ga, gl);
        check_val("pre_rst_wren", 32'(rd_wren_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        m_losses = 0; m_wren = 0; m_addr = 0; m_data = 0; m_src = 0;
        check_rd("async_rst");
        check_val("async_rst_ready", 32'(lsu_ready_o), 32'd0);
        @(posedge clk_i); #1;
        check_rd("rst_hold");
        rst_ni = 1'b1;
        lsu_valid_i = 1'b0;

        // randomized traffic honouring hold-while-not-ready
        p_av = 0; p_lv = 0; p_aa = 0; p_la = 0; p_ad = 0; p_ld = 0;
        for (int c = 0; c < 500; c++) begin
            logic fl;
            fl = ($urandom_range(0, 15) == 0);
            step(p_av, p_aa, p_ad, p_lv, p_la, p_ld, fl, ga, gl);
            if (!p_av || ga) begin
                p_av = ($urandom_range(0, 3) != 0);
                p_aa = 5'($urandom); p_ad = $urandom;
            end
            if (!p_lv || gl) begin
                p_lv = ($urandom_range(0, 3) != 0);
                p_la = 5'($urandom); p_ld = $urandom;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
